// File: rtl/ex_forward_ctrl_if.sv
// ID-side decoded fields into the EX forwarding controller and operand-mux selects/stall back out.
// master = ID/datapath side, slave = ex_forward_ctrl.
interface ex_forward_ctrl_if #(
  parameter int NB_REG    = 5,
  parameter int NB_SELECT = 2,
  parameter int NB_CNT    = 16
);
  logic                 i_valid;
  logic [NB_REG-1:0]    i_rs;
  logic [NB_REG-1:0]    i_rt;
  logic [NB_REG-1:0]    i_rd_dest;
  logic                 i_reg_write;
  logic                 i_mem_read;
  logic                 i_flush;
  logic [NB_SELECT-1:0] o_sel_a;
  logic [NB_SELECT-1:0] o_sel_b;
  logic                 o_stall;
  logic [NB_CNT-1:0]    o_stall_count;

  modport master (
    output i_valid, i_rs, i_rt, i_rd_dest, i_reg_write, i_mem_read, i_flush,
    input  o_sel_a, o_sel_b, o_stall, o_stall_count
  );

  modport slave (
    input  i_valid, i_rs, i_rt, i_rd_dest, i_reg_write, i_mem_read, i_flush,
    output o_sel_a, o_sel_b, o_stall, o_stall_count
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding/hazard control: shadow EX/MEM/WB pipeline drives operand-mux selects (from state only) and a one-cycle load-use stall.
// Define FWD_WB2_EN to add a WB2 shadow stage and select 11 for register files without write-through.
module ex_forward_ctrl #(
  parameter int NB_REG    = 5,
  parameter int NB_SELECT = 2,
  parameter int NB_CNT    = 16
) (
  input logic               i_clock,
  input logic               i_reset,
  ex_forward_ctrl_if.slave  fwd
);

  typedef struct packed {
    logic              vld;
    logic              rw;
    logic              mr;
    logic [NB_REG-1:0] dest;
  } stage_t;

  typedef struct packed {
    stage_t            st;
    logic [NB_REG-1:0] rs;
    logic [NB_REG-1:0] rt;
  } ex_t;

  localparam logic [NB_SELECT-1:0] SEL_RF  = NB_SELECT'(0);
  localparam logic [NB_SELECT-1:0] SEL_MEM = NB_SELECT'(1);
  localparam logic [NB_SELECT-1:0] SEL_WB  = NB_SELECT'(2);
`ifdef FWD_WB2_EN
  localparam logic [NB_SELECT-1:0] SEL_WB2 = NB_SELECT'(3);
`endif

  ex_t               ex_q,  ex_d;
  stage_t            mem_q, mem_d;
  stage_t            wb_q,  wb_d;
`ifdef FWD_WB2_EN
  stage_t            wb2_q, wb2_d;
`endif
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [NB_SELECT-1:0] sel_a, sel_b;
  logic              stall;

  function automatic logic hit(input stage_t s, input logic [NB_REG-1:0] src);
    return s.vld && s.rw && (s.dest != '0) && (s.dest == src);
  endfunction

  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    // Youngest producer wins; a bubble in EX never forwards.
    if (ex_q.st.vld) begin
      if (hit(mem_q, ex_q.rs))      sel_a = SEL_MEM;
      else if (hit(wb_q, ex_q.rs))  sel_a = SEL_WB;
`ifdef FWD_WB2_EN
      else if (hit(wb2_q, ex_q.rs)) sel_a = SEL_WB2;
`endif
      if (hit(mem_q, ex_q.rt))      sel_b = SEL_MEM;
      else if (hit(wb_q, ex_q.rt))  sel_b = SEL_WB;
`ifdef FWD_WB2_EN
      else if (hit(wb2_q, ex_q.rt)) sel_b = SEL_WB2;
`endif
    end
  end

  always_comb begin
    stall = fwd.i_valid && !fwd.i_flush && ex_q.st.vld && ex_q.st.mr &&
            (ex_q.st.dest != '0) &&
            ((ex_q.st.dest == fwd.i_rs) || (ex_q.st.dest == fwd.i_rt));

    ex_d = '0;
    if (fwd.i_valid && !stall && !fwd.i_flush) begin
      ex_d.st.vld  = 1'b1;
      ex_d.st.rw   = fwd.i_reg_write;
      ex_d.st.mr   = fwd.i_mem_read;
      ex_d.st.dest = fwd.i_rd_dest;
      ex_d.rs      = fwd.i_rs;
      ex_d.rt      = fwd.i_rt;
    end
    mem_d = ex_q.st;
    wb_d  = mem_q;
`ifdef FWD_WB2_EN
    wb2_d = wb_q;
`endif
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
`ifdef FWD_WB2_EN
      wb2_q <= '0;
`endif
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
`ifdef FWD_WB2_EN
      wb2_q <= wb2_d;
`endif
      cnt_q <= cnt_d;
    end
  end

  // mem_read only matters while the producer sits in EX.
`ifdef FWD_WB2_EN
  logic unused_mr;
  assign unused_mr = ^{mem_q.mr, wb_q.mr, wb2_q.mr};
`else
  logic unused_mr;
  assign unused_mr = ^{mem_q.mr, wb_q.mr};
`endif

  assign fwd.o_sel_a       = sel_a;
  assign fwd.o_sel_b       = sel_b;
  assign fwd.o_stall       = stall;
  assign fwd.o_stall_count = cnt_q;

endmodule
